// File: rtl/vector_dot_seq.sv
// ---------------------------------------------------------------------------
// vector_dot_seq
//   Sequential dot product of two LEN-element vectors. A vector pair is
//   captured on accept, then LANES element products are folded into the
//   accumulator on every BUSY cycle, so a result takes LEN/LANES cycles.
//   A result can optionally be added onto the previous result (acc_en).
//   All arithmetic wraps modulo 2^WIDTH.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     a, b and acc_en are valid this cycle
//   in_ready     block is idle and can take a new vector pair
//   a, b         operand vectors, element i at index i
//   acc_en       1: new result adds onto the previous result, 0: onto zero
//   out_valid    dot_product holds a finished result
//   out_ready    downstream consumes the result
//   dot_product  finished result while out_valid, else the last result
// ---------------------------------------------------------------------------
module vector_dot_seq #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a [LEN-1:0],
  input  logic [WIDTH-1:0] b [LEN-1:0],
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dot_product
);

  // Ternary keeps the modulo from being evaluated when LANES is zero.
  localparam bit BAD_CFG = (LANES < 1) ? 1'b1 : ((LEN % LANES) != 0);

  generate
    if (BAD_CFG) begin : g_bad_cfg
      $error("vector_dot_seq: LANES must be >= 1 and divide LEN");
    end
  endgenerate

  localparam int N     = (LANES >= 1) ? (LEN / LANES) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int EL_W  = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   dot_q, dot_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_q [LEN-1:0];
  logic [WIDTH-1:0]   b_q [LEN-1:0];
  logic [WIDTH-1:0]   a_d [LEN-1:0];
  logic [WIDTH-1:0]   b_d [LEN-1:0];
  logic [WIDTH-1:0]   lane_sum;
  logic [WIDTH-1:0]   acc_next;
  logic               accept;

  // Products of the current slice; each product and the running sum are
  // kept at WIDTH bits, which gives the modulo-2^WIDTH wrap for free.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [EL_W-1:0]  el;
      logic [WIDTH-1:0] prod;
      el       = EL_W'(int'(idx_q) * LANES + k);
      prod     = a_q[el] * b_q[el];
      lane_sum = lane_sum + prod;
    end
    acc_next = acc_q + lane_sum;
  end

  // in_ready_q is registered and equals (state_q == IDLE).
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    last_d      = last_q;
    dot_d       = dot_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d        = a;
          b_d        = b;
          idx_d      = '0;
          acc_d      = acc_en ? last_q : '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          dot_d       = acc_next;
        end
      end
      DONE: begin
        // in_ready stays low through the handshake cycle itself.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          last_d      = acc_q;
          dot_d       = acc_q;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result state; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      last_q      <= '0;
      dot_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
      dot_q       <= dot_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand capture; only read in BUSY, so no reset is needed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign dot_product = dot_q;

endmodule

// File: tb/tb_vector_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_vector_dot_seq
//   Three instances: 0 = WIDTH 32 / LANES 2, 1 = WIDTH 8 / LANES 2,
//   2 = WIDTH 32 / LANES 8. Expected results are pushed to a scoreboard
//   queue when an operation is issued and popped when out_valid rises.
// ---------------------------------------------------------------------------
module tb_vector_dot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = '0;
  logic [2:0]  ordy = '0;
  logic        acc_en = 1'b0;
  logic [31:0] a [7:0];
  logic [31:0] b [7:0];
  logic [7:0]  a8 [7:0];
  logic [7:0]  b8 [7:0];

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] dp0, dp2;
  logic [7:0]  dp1;

  logic [31:0] last [3];
  logic [31:0] sb_q [$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      a8[i] = a[i][7:0];
      b8[i] = b[i][7:0];
    end
  end

  vector_dot_seq #(.WIDTH(32), .LEN(8), .LANES(2)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(a), .b(b),
    .acc_en(acc_en), .out_valid(ov0), .out_ready(ordy[0]), .dot_product(dp0)
  );

  vector_dot_seq #(.WIDTH(8), .LEN(8), .LANES(2)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(a8), .b(b8),
    .acc_en(acc_en), .out_valid(ov1), .out_ready(ordy[1]), .dot_product(dp1)
  );

  vector_dot_seq #(.WIDTH(32), .LEN(8), .LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .a(a), .b(b),
    .acc_en(acc_en), .out_valid(ov2), .out_ready(ordy[2]), .dot_product(dp2)
  );

  function automatic logic get_ir(input int s);
    return (s == 0) ? ir0 : (s == 1) ? ir1 : ir2;
  endfunction

  function automatic logic get_ov(input int s);
    return (s == 0) ? ov0 : (s == 1) ? ov1 : ov2;
  endfunction

  function automatic logic [31:0] get_dp(input int s);
    return (s == 0) ? dp0 : (s == 1) ? {24'd0, dp1} : dp2;
  endfunction

  // Reference: plain sum of products, reduced to the instance width.
  function automatic logic [31:0] model(input int s, input logic ae);
    logic [63:0] sum;
    logic [63:0] mask;
    mask = (s == 1) ? 64'hFF : 64'hFFFF_FFFF;
    sum  = ae ? {32'd0, last[s]} : 64'd0;
    for (int i = 0; i < 8; i++)
      sum = sum + (({32'd0, a[i]} & mask) * ({32'd0, b[i]} & mask));
    return 32'(sum & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < 8; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
    acc_en = $urandom_range(0, 1);
  endtask

  // Issue one operation on instance s from the current a/b, hold the result
  // for `hold` cycles with new data offered, then consume it.
  task automatic run_op(input int s, input logic ae, input int hold);
    int          lat;
    int          n_exp;
    logic [31:0] exp;
    logic [31:0] held;
    n_exp = (s == 2) ? 1 : 4;
    chk("idle_in_ready", 32'(get_ir(s)), 32'd1);
    acc_en = ae;
    iv[s]  = 1'b1;
    sb_q.push_back(model(s, ae));
    tick();
    iv[s] = 1'b0;
    scramble();
    lat = 0;
    while (!get_ov(s) && lat < 20) begin
      if (lat == 0) chk("busy_in_ready", 32'(get_ir(s)), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(n_exp));
    exp = sb_q.pop_front();
    chk("result", get_dp(s), exp);
    held = get_dp(s);
    for (int h = 0; h < hold; h++) begin
      iv[s] = 1'b1;
      scramble();
      tick();
      chk("bp_out_valid", 32'(get_ov(s)), 32'd1);
      chk("bp_in_ready", 32'(get_ir(s)), 32'd0);
      chk("bp_stable", get_dp(s), held);
    end
    iv[s]   = 1'b0;
    ordy[s] = 1'b1;
    chk("done_in_ready", 32'(get_ir(s)), 32'd0);
    tick();
    ordy[s] = 1'b0;
    chk("consumed_out_valid", 32'(get_ov(s)), 32'd0);
    chk("consumed_in_ready", 32'(get_ir(s)), 32'd1);
    chk("last_shown", get_dp(s), exp);
    last[s] = exp;
  endtask

  task automatic set_basic();
    for (int i = 0; i < 8; i++) begin
      a[i] = 32'(i + 1);
      b[i] = 32'd1;
    end
  endtask

  task automatic set_fill(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < 8; i++) begin
      a[i] = av;
      b[i] = bv;
    end
  endtask

  initial begin
    logic seen_ov;
    for (int s = 0; s < 3; s++) last[s] = '0;
    set_fill(32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("rst_in_ready", 32'(get_ir(s)), 32'd1);
      chk("rst_out_valid", 32'(get_ov(s)), 32'd0);
      chk("rst_dot", get_dp(s), 32'd0);
    end

    // Basic, accumulate, plain again with backpressure.
    set_basic();
    run_op(0, 1'b0, 0);
    chk("basic_value", last[0], 32'd36);
    set_fill(32'd2, 32'd2);
    run_op(0, 1'b1, 0);
    chk("accum_value", last[0], 32'd68);
    set_fill(32'd2, 32'd2);
    run_op(0, 1'b0, 5);
    chk("plain_value", last[0], 32'd32);

    // Wrap at WIDTH 8.
    set_fill(32'd15, 32'd15);
    run_op(1, 1'b0, 0);
    chk("wrap_value", last[1], 32'd8);
    set_fill(32'd255, 32'd1);
    run_op(1, 1'b0, 1);
    chk("wrap_neg_value", last[1], 32'd248);

    // Single-cycle configuration.
    for (int i = 0; i < 8; i++) begin
      a[i] = 32'(i + 1);
      b[i] = 32'(8 - i);
    end
    run_op(2, 1'b0, 0);
    chk("single_value", last[2], 32'd120);

    // Reset in the middle of BUSY: the operation must vanish.
    set_basic();
    acc_en = 1'b1;
    iv[0]  = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(get_ir(0)), 32'd1);
    chk("midrst_dot", get_dp(0), 32'd0);
    seen_ov = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (get_ov(0)) seen_ov = 1'b1;
      tick();
    end
    chk("midrst_no_out_valid", 32'(seen_ov), 32'd0);
    for (int s = 0; s < 3; s++) last[s] = '0;
    set_basic();
    run_op(0, 1'b1, 0);
    chk("post_rst_value", last[0], 32'd36);

    // Randomised operations across all instances.
    for (int r = 0; r < 9; r++) begin
      int s;
      s = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin
        a[i] = $urandom;
        b[i] = $urandom;
      end
      run_op(s, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vector_dot_seq.md
VECTOR_DOT_SEQ -- requirements
Module: vector_dot_seq

Interface
REQ-001 Parameter: WIDTH, 32, bit width of every vector element, partial product and result.
REQ-002 Parameter: LEN, 8, number of elements per input vector.
REQ-003 Parameter: LANES, 2, element products summed per compute cycle; LEN % LANES != 0 or LANES < 1 SHALL be an elaboration error.
REQ-004 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: in_valid  input  1  a, b and acc_en valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a new vector pair.
REQ-008 Port: a  input  WIDTH x LEN (unpacked array [LEN-1:0])  first operand vector.
REQ-009 Port: b  input  WIDTH x LEN (unpacked array [LEN-1:0])  second operand vector.
REQ-010 Port: acc_en  input  1  when 1, the new result adds onto the previous result instead of zero.
REQ-011 Port: out_valid  output  1  dot_product holds a finished result.
REQ-012 Port: out_ready  input  1  downstream consumes the result.
REQ-013 Port: dot_product  output  WIDTH  result, modulo 2^WIDTH.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept = in_valid && in_ready; on accept, a, b and acc_en are registered, idx cleared to 0, acc loaded with the last result if acc_en = 1, else 0, and state goes IDLE->BUSY.
REQ-016 Inputs a, b and acc_en SHALL be ignored outside the accept cycle; later input changes do not affect the operation in flight.
REQ-017 Each BUSY edge: acc += sum over k = 0..LANES-1 of a[idx*LANES+k]*b[idx*LANES+k], each product and the sum truncated to WIDTH bits; idx += 1.
REQ-018 After N = LEN/LANES BUSY edges, state SHALL go BUSY->DONE; out_valid rises exactly N cycles after the accept cycle (LEN=8, LANES=2: 4 cycles).
REQ-019 In DONE, dot_product and out_valid SHALL hold stable until out_ready = 1; on that edge state goes DONE->IDLE and the result is kept in the last-result register.
REQ-020 in_ready SHALL stay 0 in BUSY and in DONE, including the DONE cycle in which out_ready = 1; at most one operation is in flight.
REQ-021 Overflow SHALL wrap silently modulo 2^WIDTH, with no saturation and no flag; signed and unsigned operands give the same bit pattern.
REQ-022 When LANES = LEN, N = 1 and out_valid SHALL rise one cycle after accept.
REQ-023 dot_product SHALL show the last-result register whenever out_valid = 0.

Reset
REQ-024 On a clk edge with rst = 1, from any state: state goes to IDLE; acc, idx, the last result and dot_product go to 0; out_valid goes to 0; in_ready reads 1 from the first cycle after rst falls.
REQ-025 Reset SHALL take priority over accept, compute and out handshake in the same cycle; an operation in flight is discarded and produces no out_valid.
REQ-026 An accept with acc_en = 1 as the first operation after reset SHALL accumulate onto 0.

Verification
REQ-027 Basic (WIDTH=32, LEN=8, LANES=2): a={1..8}, b all 1, acc_en=0 -> out_valid 4 cycles after accept, dot_product=36, in_ready=0 meanwhile.
REQ-028 Accumulate: after 36 is consumed, a=b all 2, acc_en=1 -> dot_product=68; repeat with acc_en=0 -> 32.
REQ-029 Wrap (WIDTH=8): a=b all 15 -> 1800 mod 256 = 8; a all 255, b all 1 -> 248.
REQ-030 Backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 with new data -> dot_product stays stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-031 Reset mid-BUSY: rst pulse after 2 compute cycles -> out_valid never rises, next cycle dot_product=0 and in_ready=1; next accept with acc_en=1, a={1..8}, b all 1 -> 36.
REQ-032 Single-cycle (LANES=LEN=8): a={1..8}, b={8..1} -> out_valid 1 cycle after accept, dot_product=120.
